// File: rtl/config_pkg.sv
// Shared SPI configuration: word/synchroniser defaults and the target-side state enum.
// Used by spi_slave_core and the master-side blocks.
package config_pkg;

  localparam int P_SPI_DATA_W      = 8;
  localparam int P_SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchroniser for one asynchronous pad input, with a history flop
// providing single-cycle rise/fall strobes of the synchronised level.
module spi_in_sync #(
  parameter int   P_STAGES  = 2,
  parameter logic P_RST_VAL = 1'b0
) (
  input  logic clk_100,
  input  logic a_rst,
  input  logic s_rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [P_STAGES-1:0] sync_q;
  logic                hist_q;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      sync_q <= {P_STAGES{P_RST_VAL}};
      hist_q <= P_RST_VAL;
    end else if (s_rst) begin
      sync_q <= {P_STAGES{P_RST_VAL}};
      hist_q <= P_RST_VAL;
    end else begin
      sync_q <= {sync_q[P_STAGES-2:0], async_i};
      hist_q <= sync_q[P_STAGES-1];
    end
  end

  assign sync_o = sync_q[P_STAGES-1];
  assign rise_o = sync_q[P_STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[P_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 target engine: oversampled SCK/CS_N/MOSI, word deserialiser/serialiser,
// valid/ready host side. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting.
module spi_slave_core
  import config_pkg::*;
#(
  parameter int                  P_DATA_W      = P_SPI_DATA_W,
  parameter int                  P_SYNC_STAGES = P_SPI_SYNC_STAGES,
  parameter logic [P_DATA_W-1:0] P_TX_IDLE     = '0
) (
  input  logic                clk_100,
  input  logic                a_rst,
  input  logic                s_rst,
  input  logic                spi_sck,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic [P_DATA_W-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [P_DATA_W-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                busy,
  output logic                rx_overrun,
  output logic                tx_underrun
);

  localparam int                CNT_W    = $clog2(P_DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DATA_W - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise_unused, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sck_sync (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .async_i (spi_sck),
    .sync_o  (sck_sync),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_in_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b1)) u_cs_sync (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .async_i (spi_cs_n),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise_unused),
    .fall_o  (cs_fall)
  );

  spi_in_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_mosi_sync (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .async_i (spi_mosi),
    .sync_o  (mosi_sync),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  // Bit-order helpers; everything else is order-agnostic.
`ifdef SPI_SLAVE_LSB_FIRST_EN
  function automatic logic [P_DATA_W-1:0] rx_shift_in(input logic [P_DATA_W-1:0] v, input logic b);
    return {b, v[P_DATA_W-1:1]};
  endfunction
  function automatic logic [P_DATA_W-1:0] tx_shift_out(input logic [P_DATA_W-1:0] v);
    return {1'b0, v[P_DATA_W-1:1]};
  endfunction
  function automatic logic tx_bit(input logic [P_DATA_W-1:0] v);
    return v[0];
  endfunction
`else
  function automatic logic [P_DATA_W-1:0] rx_shift_in(input logic [P_DATA_W-1:0] v, input logic b);
    return {v[P_DATA_W-2:0], b};
  endfunction
  function automatic logic [P_DATA_W-1:0] tx_shift_out(input logic [P_DATA_W-1:0] v);
    return {v[P_DATA_W-2:0], 1'b0};
  endfunction
  function automatic logic tx_bit(input logic [P_DATA_W-1:0] v);
    return v[P_DATA_W-1];
  endfunction
`endif

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [P_DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [P_DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [P_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                overrun_q, overrun_d;
  logic                load_pend_q, load_pend_d;
  logic                miso_q, miso_d;
  logic                tx_load, word_done;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
    end else if (s_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    load_pend_d = load_pend_q;
    tx_load     = 1'b0;
    word_done   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // SCK edges here, including one coincident with the CS_N fall, are ignored.
        if (cs_fall) begin
          state_d     = ACTIVE;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
          tx_load     = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_sync) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_shift_in(rx_shift_q, mosi_sync);
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d   = '0;
              load_pend_d = 1'b1;
              word_done   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // The fall that closes a word fetches the next word instead of shifting.
          if (sck_fall) begin
            if (load_pend_q) begin
              tx_load     = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_out(tx_shift_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle accept frees the holding register, so no overrun then.
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (tx_load) begin
      tx_shift_d = tx_valid ? tx_data : P_TX_IDLE;
    end

    miso_d = (state_d == ACTIVE) ? tx_bit(tx_shift_d) : 1'b0;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = overrun_q;
  assign tx_ready    = tx_load & tx_valid & ~s_rst;
  assign tx_underrun = tx_load & ~tx_valid & ~s_rst;

endmodule
